// File: rtl/riscv_branch_pkg.sv
// Shared constants, FSM state type and counter helper for the branch predictor.
// Counter encodings follow the classic 2-bit scheme; bit 1 is the taken prediction.
package riscv_branch_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } bp_state_e;

    // Saturating step: strongly-taken and strongly-not-taken hold.
    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        res = ctr;
        if (taken && ctr != CTR_ST) begin
            res = ctr + 2'd1;
        end else if (!taken && ctr != CTR_SNT) begin
            res = ctr - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/bp_table.sv
// Direct-mapped prediction table: combinational fetch read, read-modify-write training port, bulk clear.
// Training reads the entry at the update index internally, so the fetch port never sees a bypass.
module bp_table
    import riscv_branch_pkg::*;
#(
    parameter  int IDX_BITS = 4,
    localparam int TAG_W    = 30 - IDX_BITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr_i,
    input  logic [IDX_BITS-1:0] rd_idx_i,
    output logic                rd_valid_o,
    output logic [TAG_W-1:0]    rd_tag_o,
    output logic [29:0]         rd_target_o,
    output logic [1:0]          rd_ctr_o,
    input  logic                wr_en_i,
    input  logic [IDX_BITS-1:0] wr_idx_i,
    input  logic [TAG_W-1:0]    wr_tag_i,
    input  logic [29:0]         wr_target_i,
    input  logic                wr_taken_i
);

    localparam int DEPTH = 1 << IDX_BITS;

    logic [DEPTH-1:0] valid_q;
    logic [TAG_W-1:0] tag_q    [DEPTH];
    logic [29:0]      target_q [DEPTH];
    logic [1:0]       ctr_q    [DEPTH];

    logic wr_hit;

    assign rd_valid_o  = valid_q[rd_idx_i];
    assign rd_tag_o    = tag_q[rd_idx_i];
    assign rd_target_o = target_q[rd_idx_i];
    assign rd_ctr_o    = ctr_q[rd_idx_i];

    assign wr_hit = valid_q[wr_idx_i] && (tag_q[wr_idx_i] == wr_tag_i);

    // Clear has priority over training in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n || clr_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_WNT;
            end
        end else if (wr_en_i) begin
            if (wr_taken_i) begin
                valid_q[wr_idx_i]  <= 1'b1;
                tag_q[wr_idx_i]    <= wr_tag_i;
                target_q[wr_idx_i] <= wr_target_i;
                ctr_q[wr_idx_i]    <= wr_hit ? ctr_step(ctr_q[wr_idx_i], 1'b1) : CTR_WT;
            end else if (wr_hit) begin
                ctr_q[wr_idx_i] <= ctr_step(ctr_q[wr_idx_i], 1'b0);
            end
        end
    end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Branch predictor front end plus EX-stage resolution: redirect, flush sequencing and statistics.
// A mispredict flushes for FLUSH_CYCLES cycles; wrong-path EX branches are ignored meanwhile.
module branch_predict_ctrl
    import riscv_branch_pkg::*;
#(
    parameter int IDX_BITS     = 4,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc,
    output logic        if_pred_taken,
    output logic [31:0] if_next_pc,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic        ex_taken,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    input  logic        tbl_clear,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush_o,
    output logic [31:0] br_count,
    output logic [31:0] mispred_count
);

    localparam int TAG_W = 30 - IDX_BITS;

    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [29:0]      rd_target;
    logic [1:0]       rd_ctr;
    logic             fetch_hit;

    bp_state_e   state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] br_q, br_d;
    logic [31:0] mis_q, mis_d;
    logic        resolve;
    logic        mispred;
    logic [31:0] actual_pc;

    bp_table #(.IDX_BITS(IDX_BITS)) u_table (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (tbl_clear),
        .rd_idx_i    (if_pc[IDX_BITS+1:2]),
        .rd_valid_o  (rd_valid),
        .rd_tag_o    (rd_tag),
        .rd_target_o (rd_target),
        .rd_ctr_o    (rd_ctr),
        .wr_en_i     (resolve),
        .wr_idx_i    (ex_pc[IDX_BITS+1:2]),
        .wr_tag_i    (ex_pc[31:IDX_BITS+2]),
        .wr_target_i (ex_target[31:2]),
        .wr_taken_i  (ex_taken)
    );

    assign fetch_hit     = rd_valid && (rd_tag == if_pc[31:IDX_BITS+2]);
    assign if_pred_taken = fetch_hit && rd_ctr[1];
    assign if_next_pc    = if_pred_taken ? {rd_target, 2'b00} : if_pc + 32'd4;

    assign resolve   = ex_valid && ex_is_branch && (state_q == ST_IDLE);
    assign actual_pc = ex_taken ? ex_target : ex_pc + 32'd4;
    assign mispred   = resolve && ((ex_taken != ex_pred_taken) ||
                                   (ex_taken && (ex_pred_target != ex_target)));

    assign redirect_valid = mispred;
    assign redirect_pc    = actual_pc;
    assign flush_o        = mispred || (state_q == ST_FLUSH);
    assign br_count       = br_q;
    assign mispred_count  = mis_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (mispred && FLUSH_CYCLES > 1) begin
                    state_d = ST_FLUSH;
                    cnt_d   = 3'(FLUSH_CYCLES - 1);
                end
            end
            ST_FLUSH: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    assign br_d  = (resolve && br_q != 32'hFFFF_FFFF) ? br_q + 32'd1 : br_q;
    assign mis_d = (mispred && mis_q != 32'hFFFF_FFFF) ? mis_q + 32'd1 : mis_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            br_q    <= 32'd0;
            mis_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            mis_q   <= mis_d;
        end
    end

endmodule
